// File: rtl/mem_access.sv
// mem_access: MIPS byte/half/word load-store stage between EX/MEM and MEM/WB.
// Drives a req/ack data bus and stalls upstream while a transfer is pending.
module mem_access #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic              write_en_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] write_data_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic              write_en_o,
  output logic              valid_o,
  output logic              stall_req_o,
  output logic              addr_err_o,
  output logic              dbus_req_o,
  output logic              dbus_wr_o,
  output logic [DATA_W-1:0] dbus_addr_o,
  output logic [3:0]        dbus_be_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  input  logic              dbus_ack_i,
  input  logic [DATA_W-1:0] dbus_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state, state_nx;

  logic              is_load, is_store, is_signed;
  logic              is_mem, aligned, accept;
  logic [1:0]        size;
  logic [1:0]        off;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;

  logic [1:0]        size_q, off_q;
  logic              signed_q, en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] lane, load_data;

  assign off    = write_data_i[1:0];
  assign is_mem = is_load | is_store;
  assign accept = (state == IDLE) & valid_i & ~flush_i;
  assign dbus_req_o = (state != IDLE);

  // size: 0 byte, 1 half, 2 word
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = 2'd0;
    case (mem_op_i)
      4'd1: begin is_load = 1'b1; is_signed = 1'b1; end
      4'd2: is_load = 1'b1;
      4'd3: begin is_load = 1'b1; is_signed = 1'b1; size = 2'd1; end
      4'd4: begin is_load = 1'b1; size = 2'd1; end
      4'd5: begin is_load = 1'b1; size = 2'd2; end
      4'd6: is_store = 1'b1;
      4'd7: begin is_store = 1'b1; size = 2'd1; end
      4'd8: begin is_store = 1'b1; size = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    be      = 4'b1111;
    wdata   = store_data_i;
    case (size)
      2'd0: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data_i[7:0]}};
      end
      2'd1: begin
        aligned = ~off[0];
        be      = off[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{store_data_i[15:0]}};
      end
      default: aligned = (off == 2'b00);
    endcase
  end

  always_comb begin
    state_nx    = state;
    stall_req_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && is_mem && aligned) begin
          state_nx    = BUSY;
          stall_req_o = 1'b1;
        end
      end
      BUSY: begin
        if (dbus_ack_i) begin
          state_nx = IDLE;
        end else begin
          stall_req_o = 1'b1;
          if (flush_i) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (dbus_ack_i) state_nx = IDLE;
        else stall_req_o = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  // Halfword offsets are even, so the same shift selects either lane kind.
  always_comb begin
    lane = dbus_rdata_i >> {off_q, 3'b000};
    unique case (size_q)
      2'd0: load_data = {{(DATA_W-8){signed_q & lane[7]}}, lane[7:0]};
      2'd1: load_data = {{(DATA_W-16){signed_q & lane[15]}}, lane[15:0]};
      default: load_data = dbus_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      write_data_o <= '0;
      write_addr_o <= '0;
      write_en_o   <= 1'b0;
      valid_o      <= 1'b0;
      addr_err_o   <= 1'b0;
      dbus_wr_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      size_q       <= '0;
      off_q        <= '0;
      signed_q     <= 1'b0;
      en_q         <= 1'b0;
      addr_q       <= '0;
    end else begin
      valid_o    <= 1'b0;
      addr_err_o <= 1'b0;
      if (accept) begin
        if (is_mem && aligned) begin
          dbus_wr_o    <= is_store;
          dbus_addr_o  <= {write_data_i[DATA_W-1:2], 2'b00};
          dbus_be_o    <= be;
          dbus_wdata_o <= wdata;
          size_q       <= size;
          off_q        <= off;
          signed_q     <= is_signed;
          en_q         <= write_en_i & is_load;
          addr_q       <= write_addr_i;
        end else begin
          valid_o      <= 1'b1;
          addr_err_o   <= is_mem;
          write_data_o <= write_data_i;
          write_addr_o <= write_addr_i;
          write_en_o   <= write_en_i & ~is_mem;
        end
      end
      if (state == BUSY && dbus_ack_i && !flush_i) begin
        valid_o      <= 1'b1;
        write_data_o <= load_data;
        write_addr_o <= addr_q;
        write_en_o   <= en_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access
// against a transaction-level model of the load/store rules.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] write_data_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  write_addr_i = '0;
  logic        write_en_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] write_data_o;
  logic [4:0]  write_addr_o;
  logic        write_en_o, valid_o, stall_req_o, addr_err_o;
  logic        dbus_req_o, dbus_wr_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_ack_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .write_data_i(write_data_i), .store_data_i(store_data_i),
    .write_addr_i(write_addr_i), .write_en_i(write_en_i),
    .flush_i(flush_i), .write_data_o(write_data_o),
    .write_addr_o(write_addr_o), .write_en_o(write_en_o),
    .valid_o(valid_o), .stall_req_o(stall_req_o),
    .addr_err_o(addr_err_o), .dbus_req_o(dbus_req_o),
    .dbus_wr_o(dbus_wr_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic int nbytes(input int op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_st(input int op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic int lane_of(input int n, input logic [31:0] a);
    return int'(a[1:0]) & (4 - n);
  endfunction

  function automatic logic [3:0] exp_be(input int n, input logic [31:0] a);
    int v = ((1 << n) - 1) << lane_of(n, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input int n, input logic [31:0] d);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_ld(input int op, input logic [31:0] a,
                                         input logic [31:0] rd);
    int n = nbytes(op);
    longint unsigned r = 64'(rd);
    longint unsigned top = 64'd1 << (8 * n);
    longint unsigned v = (r >> (8 * lane_of(n, a))) & (top - 1);
    if ((op == 1 || op == 3) && v >= (top >> 1)) v = v - top;
    return v[31:0];
  endfunction

  // Called at posedge+1; returns at posedge+1 of the result cycle.
  task automatic do_op(input int op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd,
                       input logic [4:0] wa, input logic we,
                       input int waits, input int fl, output int rc);
    int n = nbytes(op);
    bit flushed = 0;
    rc = -1;
    valid_i = 1'b1; mem_op_i = op[3:0]; write_data_i = a;
    store_data_i = sd; write_addr_i = wa; write_en_i = we; flush_i = 1'b0;
    @(negedge clk);
    if (n == 0) begin
      chk("stall_none", stall_req_o, 0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("valid_none", valid_o, 1);
      chk("wdata_none", write_data_o, a);
      chk("waddr_none", write_addr_o, wa);
      chk("wen_none", write_en_o, we);
      chk("err_none", addr_err_o, 0);
      chk("req_none", dbus_req_o, 0);
    end else if (a % n != 0) begin
      chk("stall_mis", stall_req_o, 0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("valid_mis", valid_o, 1);
      chk("err_mis", addr_err_o, 1);
      chk("wen_mis", write_en_o, 0);
      chk("req_mis", dbus_req_o, 0);
      @(posedge clk); #1;
      chk("err_pulse", addr_err_o, 0);
      chk("valid_pulse", valid_o, 0);
    end else begin
      chk("stall_acc", stall_req_o, 1);
      @(posedge clk); #1;
      rc = cyc;
      for (int i = 0; i <= waits; i++) begin
        dbus_ack_i = (i == waits);
        flush_i = (i == fl);
        if (i == fl) flushed = 1;
        dbus_rdata_i = dbus_ack_i ? rd : $urandom;
        @(negedge clk);
        chk("req_busy", dbus_req_o, 1);
        chk("bus_addr", dbus_addr_o, a & ~32'h3);
        chk("bus_be", dbus_be_o, exp_be(n, a));
        chk("bus_wr", dbus_wr_o, is_st(op));
        if (is_st(op)) chk("bus_wdata", dbus_wdata_o, exp_wd(n, sd));
        chk("valid_busy", valid_o, 0);
        chk("stall_busy", stall_req_o, !dbus_ack_i);
        @(posedge clk); #1;
      end
      dbus_ack_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
      chk("req_done", dbus_req_o, 0);
      chk("valid_done", valid_o, !flushed);
      if (!flushed) begin
        chk("waddr_done", write_addr_o, wa);
        chk("wen_done", write_en_o, is_st(op) ? 0 : we);
        if (!is_st(op)) chk("ld_data", write_data_o, exp_ld(op, a, rd));
      end
    end
  endtask

  int rc1, rc2;

  initial begin
    valid_i = 1'b1;
    mem_op_i = 4'd0;
    write_data_i = 32'hDEAD_BEEF;
    write_en_i = 1'b1;
    write_addr_i = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_wdata", write_data_o, 0);
    chk("rst_waddr", write_addr_o, 0);
    chk("rst_wen", write_en_o, 0);
    chk("rst_req", dbus_req_o, 0);
    chk("rst_err", addr_err_o, 0);
    chk("rst_baddr", dbus_addr_o, 0);
    rst = 1'b1;

    do_op(0, 32'h0000_00F0, 0, 0, 5'd5, 1, 0, -1, rc1);
    do_op(1, 32'h0000_1003, 0, 32'h80AB_CDEF, 5'd7, 1, 3, -1, rc1);
    do_op(2, 32'h0000_1003, 0, 32'h80AB_CDEF, 5'd7, 1, 3, -1, rc1);
    do_op(7, 32'h0000_2002, 32'h1234_5678, 0, 5'd3, 1, 1, -1, rc1);
    do_op(5, 32'h0000_3001, 0, 0, 5'd4, 1, 0, -1, rc1);
    do_op(5, 32'h0000_4000, 0, 32'h1111_2222, 5'd6, 1, 3, 1, rc1);
    chk("drain_idle_req", dbus_req_o, 0);
    do_op(8, 32'h0000_5000, 32'hCAFE_F00D, 0, 5'd1, 1, 0, -1, rc1);
    do_op(5, 32'h0000_5004, 0, 32'h0BAD_1DEA, 5'd2, 1, 0, -1, rc2);
    chk("b2b_gap", rc2 - rc1, 2);

    // flush beats a new valid in IDLE
    valid_i = 1'b1; mem_op_i = 4'd5; write_data_i = 32'h40; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", stall_req_o, 0);
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle_valid", valid_o, 0);
    chk("flush_idle_req", dbus_req_o, 0);

    // reset abandons an outstanding request
    valid_i = 1'b1; mem_op_i = 4'd5; write_data_i = 32'h80;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("mid_req", dbus_req_o, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req", dbus_req_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    rst = 1'b1;

    for (int k = 0; k < 60; k++) begin
      int op, w, fl;
      logic [31:0] a;
      op = $urandom_range(0, 15);
      a = $urandom;
      w = $urandom_range(0, 3);
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w) : -1;
      do_op(op, a, $urandom, $urandom, 5'($urandom), 1'($urandom),
            w, fl, rc1);
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
